ft245_responder: RTL

// Synthesizable device-side model of the FTDI synchronous FT245 FIFO interface; it plays the FT2232H chip.

---
 rtl/ft245_responder_if.sv | 30 +++
 rtl/ft245_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ft245_responder_if.sv
// Signal bundle between an FT245 synchronous FIFO master (FPGA side plus host streams)
// and the device-side responder that stands in for the FT2232H.
interface ft245_responder_if;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic       ft_oe_n;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic       ft_siwu_n;
  logic [7:0] ft_bus_i;
  logic [7:0] ft_bus_o;
  logic       ft_bus_oe;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] snk_data;
  logic       snk_valid;
  logic       snk_ready;

  // Environment side: drives the FPGA strobes/bus and the host streams.
  modport master (
    input  ft_rxf_n, ft_txe_n, ft_bus_o, ft_bus_oe, src_ready, snk_data, snk_valid,
    output ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_bus_i, src_data, src_valid, snk_ready
  );

  modport slave (
    output ft_rxf_n, ft_txe_n, ft_bus_o, ft_bus_oe, src_ready, snk_data, snk_valid,
    input  ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_bus_i, src_data, src_valid, snk_ready
  );
endinterface

// File: rtl/ft245_responder.sv
// Device-side model of the FTDI synchronous FT245 FIFO: an RX FIFO (host src -> FPGA)
// and a TX FIFO (FPGA -> host snk) with optional rxf_n/txe_n throttling gaps.
module ft245_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TXE_BURST  = 0,
  parameter int TXE_GAP    = 4,
  parameter int RXF_BURST  = 0,
  parameter int RXF_GAP    = 4
) (
  input  logic               i_ft_clkout,
  input  logic               i_rst,
  ft245_responder_if.slave   io_bus,
  output logic               o_err_overrun,
  output logic               o_err_contention
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_CNT    = PW'(DEPTH);
  localparam logic [15:0]   TXE_BURST_W = 16'(TXE_BURST);
  localparam logic [15:0]   TXE_GAP_W   = 16'(TXE_GAP);
  localparam logic [15:0]   RXF_BURST_W = 16'(RXF_BURST);
  localparam logic [15:0]   RXF_GAP_W   = 16'(RXF_GAP);

  logic [7:0]    r_rx_mem [DEPTH];
  logic [7:0]    r_tx_mem [DEPTH];
  logic [PW-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [15:0]   r_rx_bytes, r_rx_gap, r_tx_bytes, r_tx_gap;
  logic          r_rxf_n, r_txe_n;
  logic          r_err_overrun, r_err_contention;

  logic [PW-1:0] w_rx_count, w_tx_count, w_rx_count_next, w_tx_count_next;
  logic [15:0]   w_rx_bytes_next, w_rx_gap_next, w_tx_bytes_next, w_tx_gap_next;
  logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic          w_unused_siwu;

  // Send-immediate has no meaning for this model.
  assign w_unused_siwu = io_bus.ft_siwu_n;

  assign w_rx_count = r_rx_wptr - r_rx_rptr;
  assign w_tx_count = r_tx_wptr - r_tx_rptr;

  assign w_rx_push = io_bus.src_valid && io_bus.src_ready;
  assign w_rx_pop  = !io_bus.ft_rd_n && !io_bus.ft_oe_n && !r_rxf_n;
  assign w_tx_push = !io_bus.ft_wr_n && !r_txe_n;
  assign w_tx_pop  = io_bus.snk_valid && io_bus.snk_ready;

  assign w_rx_count_next = w_rx_count + PW'(w_rx_push) - PW'(w_rx_pop);
  assign w_tx_count_next = w_tx_count + PW'(w_tx_push) - PW'(w_tx_pop);

  assign io_bus.src_ready = !i_rst && (w_rx_count != FULL_CNT);
  assign io_bus.snk_valid = !i_rst && (w_tx_count != '0);
  assign io_bus.snk_data  = r_tx_mem[r_tx_rptr[DEPTH_LOG2-1:0]];
  assign io_bus.ft_bus_o  = r_rx_mem[r_rx_rptr[DEPTH_LOG2-1:0]];
  assign io_bus.ft_bus_oe = ~io_bus.ft_oe_n;
  assign io_bus.ft_rxf_n  = r_rxf_n;
  assign io_bus.ft_txe_n  = r_txe_n;
  assign o_err_overrun    = r_err_overrun;
  assign o_err_contention = r_err_contention;

  // Gap counters count down; the flag stays high while the counter is non-zero.
  always_comb begin
    w_rx_bytes_next = r_rx_bytes;
    w_rx_gap_next   = (r_rx_gap != '0) ? r_rx_gap - 16'd1 : '0;
    if ((RXF_BURST > 0) && w_rx_pop) begin
      if (r_rx_bytes == RXF_BURST_W - 16'd1) begin
        w_rx_bytes_next = '0;
        w_rx_gap_next   = RXF_GAP_W;
      end else begin
        w_rx_bytes_next = r_rx_bytes + 16'd1;
      end
    end
  end

  always_comb begin
    w_tx_bytes_next = r_tx_bytes;
    w_tx_gap_next   = (r_tx_gap != '0) ? r_tx_gap - 16'd1 : '0;
    if ((TXE_BURST > 0) && w_tx_push) begin
      if (r_tx_bytes == TXE_BURST_W - 16'd1) begin
        w_tx_bytes_next = '0;
        w_tx_gap_next   = TXE_GAP_W;
      end else begin
        w_tx_bytes_next = r_tx_bytes + 16'd1;
      end
    end
  end

  // Storage carries no reset; validity is defined by the pointers alone.
  always_ff @(posedge i_ft_clkout) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[DEPTH_LOG2-1:0]] <= io_bus.src_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr[DEPTH_LOG2-1:0]] <= io_bus.ft_bus_i;
  end

  always_ff @(posedge i_ft_clkout) begin
    if (i_rst) begin
      r_rx_wptr        <= '0;
      r_rx_rptr        <= '0;
      r_tx_wptr        <= '0;
      r_tx_rptr        <= '0;
      r_rx_bytes       <= '0;
      r_rx_gap         <= '0;
      r_tx_bytes       <= '0;
      r_tx_gap         <= '0;
      r_rxf_n          <= 1'b1;
      r_txe_n          <= 1'b1;
      r_err_overrun    <= 1'b0;
      r_err_contention <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      r_rx_bytes <= w_rx_bytes_next;
      r_rx_gap   <= w_rx_gap_next;
      r_tx_bytes <= w_tx_bytes_next;
      r_tx_gap   <= w_tx_gap_next;
      r_rxf_n    <= (w_rx_count_next == '0) || (w_rx_gap_next != '0);
      r_txe_n    <= (w_tx_count_next == FULL_CNT) || (w_tx_gap_next != '0);
      if (!io_bus.ft_wr_n && r_txe_n)         r_err_overrun    <= 1'b1;
      if (!io_bus.ft_oe_n && !io_bus.ft_wr_n) r_err_contention <= 1'b1;
    end
  end

endmodule
